i2c_master: RTL and testbench

Single-byte I2C controller (initiator) for the on-chip I2C slave (address 7'h55). It accepts a one-cycle command, then generates START, address+R/W, one data byte, ACK/NACK and STOP on open-drain SCL/SDA lines. In read transactions it returns the received byte. It sits between CPU/AXI-Lite register logic and the board I2C pins.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_master_if.sv | 25 ++
 rtl/i2c_qtick_gen.sv | 45 ++++
 rtl/i2c_master.sv | 172 +++++++++++++++++
 tb/tb_i2c_master.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C controller.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StWdata,
    StWack,
    StRdata,
    StRack,
    StStop
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [6:0] SlaveAddr = 7'h55;

  // Clocks of SCL readback delay through the 2-FF synchronizer.
  localparam int unsigned SyncLat = 2;

endpackage

// File: rtl/i2c_master_if.sv
// Command/status handshake between register logic (master) and the I2C controller (slave).
interface i2c_master_if #(
  parameter int unsigned ADDR_W = 7
) ();

  logic              start;
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              busy;
  logic              done;
  logic              ack_err;

  modport master (
    output start, addr, rw, wdata,
    input  rdata, busy, done, ack_err
  );

  modport slave (
    input  start, addr, rw, wdata,
    output rdata, busy, done, ack_err
  );

endinterface

// File: rtl/i2c_qtick_gen.sv
// Quarter-period tick generator: one tick every CLK_DIV clocks while enabled, 2-bit phase.
module i2c_qtick_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_hold,
  output logic       o_tick,
  output logic [1:0] o_phase
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_phase;
  logic            w_last;
  logic            w_freeze;

  assign w_last   = (r_cnt == CntW'(CLK_DIV - 1));
  // Hold is ignored for the first clocks of a quarter while the readback is still stale.
  assign w_freeze = i_hold && (r_cnt >= CntW'(SyncLat));
  assign o_tick   = i_en && !w_freeze && w_last;
  assign o_phase  = r_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= Q0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= Q0;
    end else if (!w_freeze) begin
      if (w_last) begin
        r_cnt   <= '0;
        r_phase <= r_phase + 2'd1;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, addr+R/W, one data byte, ACK/NACK, STOP on open-drain lines.
// Optional slave clock stretching is enabled with `define I2C_MASTER_STRETCH_EN.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250,
  parameter int unsigned ADDR_W  = 7
) (
  input  logic        clk,
  input  logic        reset,
  i2c_master_if.slave bus,
  inout  wire         scl,
  inout  wire         sda
);

  state_e      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic        r_rw;
  logic        r_busy;
  logic        r_done;
  logic        r_ack_err;
  logic        r_nack;
  logic        r_scl_oe;
  logic        r_sda_oe;

  logic        w_tick;
  logic        w_hold;
  logic        w_sda_in;
  logic [1:0]  w_phase;
  logic [ADDR_W:0] w_addr_rw;

  i2c_qtick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_qtick (
    .clk     (clk),
    .reset   (reset),
    .i_en    (r_busy),
    .i_hold  (w_hold),
    .o_tick  (w_tick),
    .o_phase (w_phase)
  );

  assign scl       = r_scl_oe ? 1'b0 : 1'bz;
  assign sda       = r_sda_oe ? 1'b0 : 1'bz;
  assign w_sda_in  = sda;
  assign w_addr_rw = {bus.addr, bus.rw};

  assign bus.rdata   = r_rdata;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.ack_err = r_ack_err;

`ifdef I2C_MASTER_STRETCH_EN
  logic [1:0] r_scl_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
    end
  end

  assign w_hold = r_busy && (w_phase == Q2 || w_phase == Q3) && !r_scl_sync[1];
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_rw      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_nack    <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == StIdle) begin
        if (bus.start) begin
          r_state   <= StStart;
          r_busy    <= 1'b1;
          r_rw      <= bus.rw;
          r_wdata   <= bus.wdata;
          r_shift   <= 8'(w_addr_rw);
          r_ack_err <= 1'b0;
          r_nack    <= 1'b0;
        end
      end else if (w_tick) begin
        // w_phase is the quarter that is ending on this tick.
        unique case (w_phase)
          Q1: begin
            r_scl_oe <= 1'b0;
            if (r_state == StStart) r_sda_oe <= 1'b1;
          end
          Q2: begin
            if (r_state == StAddrAck || r_state == StWack) r_nack <= r_nack | w_sda_in;
            if (r_state == StRdata) r_shift <= {r_shift[6:0], w_sda_in};
            if (r_state == StStop) r_sda_oe <= 1'b0;
          end
          Q3: begin
            r_scl_oe <= 1'b1;
            unique case (r_state)
              StStart: begin
                r_state   <= StAddr;
                r_bit_cnt <= '0;
                r_sda_oe  <= ~r_shift[7];
              end
              StAddr, StWdata: begin
                if (r_bit_cnt == 3'd7) begin
                  r_sda_oe <= 1'b0;
                  r_state  <= (r_state == StAddr) ? StAddrAck : StWack;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  r_shift   <= {r_shift[6:0], 1'b0};
                  r_sda_oe  <= ~r_shift[6];
                end
              end
              StAddrAck: begin
                r_bit_cnt <= '0;
                if (r_nack) begin
                  r_state  <= StStop;
                  r_sda_oe <= 1'b1;
                end else if (r_rw) begin
                  r_state  <= StRdata;
                  r_sda_oe <= 1'b0;
                end else begin
                  r_state  <= StWdata;
                  r_shift  <= r_wdata;
                  r_sda_oe <= ~r_wdata[7];
                end
              end
              StWack: begin
                r_state  <= StStop;
                r_sda_oe <= 1'b1;
              end
              StRdata: begin
                if (r_bit_cnt == 3'd7) r_state <= StRack;
                else r_bit_cnt <= r_bit_cnt + 3'd1;
              end
              StRack: begin
                r_rdata  <= r_shift;
                r_state  <= StStop;
                r_sda_oe <= 1'b1;
              end
              StStop: begin
                r_state   <= StIdle;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_ack_err <= r_nack;
                r_scl_oe  <= 1'b0;
                r_sda_oe  <= 1'b0;
              end
              default: r_state <= StIdle;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master with a clock-sampled I2C slave model at address 7'h55.
// Builds the clock-stretching scenario when I2C_MASTER_STRETCH_EN is defined.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int D     = 10;
  localparam int Limit = 100 * D;

  localparam int SIdle    = 0;
  localparam int SAddr    = 1;
  localparam int SAddrAck = 2;
  localparam int SWrx     = 3;
  localparam int SWack    = 4;
  localparam int SRtx     = 5;
  localparam int SRack    = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  wire  scl;
  wire  sda;

  pullup (scl);
  pullup (sda);

  logic slv_sda_low = 1'b0;
  logic slv_scl_low = 1'b0;
  assign sda = slv_sda_low ? 1'b0 : 1'bz;
  assign scl = slv_scl_low ? 1'b0 : 1'bz;

  i2c_master_if #(.ADDR_W(7)) bus ();

  i2c_master #(
    .CLK_DIV (D),
    .ADDR_W  (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .scl   (scl),
    .sda   (sda)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model state
  int         s_phase = SIdle;
  int         s_bits = 0;
  int         s_starts = 0;
  int         s_stops = 0;
  int         s_hold = 0;
  int         s_stretches = 0;
  bit         s_arm = 1'b0;
  logic [7:0] s_byte = 8'h00;
  logic [7:0] s_mem = 8'h00;
  logic [7:0] s_tx = 8'h00;
  logic       s_rw = 1'b0;
  logic       s_mack = 1'b0;
  logic       s_prev_scl = 1'b1;
  logic       s_prev_sda = 1'b1;
  logic       cur_scl;
  logic       cur_sda;
  int         done_cnt = 0;

  // Reference model: what the slave memory and the controller's rdata should hold.
  logic [7:0] m_mem = 8'h00;
  logic [7:0] m_rdata = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      cur_scl = (scl !== 1'b0);
      cur_sda = (sda !== 1'b0);
      if (s_hold > 0) begin
        s_hold--;
        if (s_hold == 0) slv_scl_low = 1'b0;
      end
      if (s_prev_scl && cur_scl && s_prev_sda && !cur_sda) begin
        s_starts++;
        s_phase = SAddr;
        s_bits = 0;
        s_byte = 8'h00;
        slv_sda_low = 1'b0;
      end else if (s_prev_scl && cur_scl && !s_prev_sda && cur_sda) begin
        s_stops++;
        s_phase = SIdle;
        slv_sda_low = 1'b0;
      end else if (!s_prev_scl && cur_scl) begin
        if (s_phase == SAddr || s_phase == SWrx) begin
          s_byte = {s_byte[6:0], cur_sda};
          s_bits++;
        end else if (s_phase == SRack) begin
          s_mack = cur_sda;
        end
      end else if (s_prev_scl && !cur_scl) begin
        case (s_phase)
          SAddr: if (s_bits == 8) begin
            if (s_byte[7:1] == SlaveAddr) begin
              slv_sda_low = 1'b1;
              s_rw = s_byte[0];
              s_phase = SAddrAck;
            end else begin
              s_phase = SIdle;
            end
          end
          SAddrAck: begin
            slv_sda_low = 1'b0;
            s_bits = 0;
            s_byte = 8'h00;
            if (s_rw) begin
              s_tx = s_mem;
              slv_sda_low = !s_tx[7];
              s_bits = 1;
              s_phase = SRtx;
            end else begin
              s_phase = SWrx;
            end
          end
          SWrx: begin
            if (s_arm && s_stretches == 0 && s_bits == 3) begin
              slv_scl_low = 1'b1;
              s_hold = 5 * D;
              s_stretches++;
            end
            if (s_bits == 8) begin
              s_mem = s_byte;
              slv_sda_low = 1'b1;
              s_phase = SWack;
            end
          end
          SWack: begin
            slv_sda_low = 1'b0;
            s_phase = SIdle;
          end
          SRtx: if (s_bits == 8) begin
            slv_sda_low = 1'b0;
            s_phase = SRack;
          end else begin
            s_tx = {s_tx[6:0], 1'b0};
            slv_sda_low = !s_tx[7];
            s_bits++;
          end
          SRack: s_phase = SIdle;
          default: ;
        endcase
      end
      s_prev_scl = cur_scl;
      s_prev_sda = cur_sda;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command and count clocks from the accepting edge to the done pulse.
  task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         output int cyc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = a;
    bus.rw    = rw;
    bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < Limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Model of one transaction's outcome from the protocol rules.
  task automatic model_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                           input int extra, output logic exp_err, output int exp_cyc);
    exp_err = (a != SlaveAddr);
    exp_cyc = (exp_err ? 44 * D : 80 * D) + extra;
    if (!exp_err && rw) m_rdata = m_mem;
    if (!exp_err && !rw) m_mem = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 00", bus.rdata);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b want 0", bus.done);
    end
    n_checks++;
    if (bus.ack_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_ack_err: got %b want 0", bus.ack_err);
    end
    n_checks++;
    if (scl !== 1'b1 || sda !== 1'b1) begin
      n_fail++; $display("FAIL reset_lines: got scl=%b sda=%b want 1 1", scl, sda);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || scl !== 1'b1 || sda !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_idle: got busy=%b scl=%b sda=%b want 0 1 1",
                         bus.busy, scl, sda);
    end
  endtask

  task automatic check_txn(input string name, input logic [6:0] a, input logic rw,
                           input logic [7:0] wd, input int extra);
    int   cyc;
    int   exp_cyc;
    int   st0;
    int   sp0;
    logic exp_err;
    st0 = s_starts;
    sp0 = s_stops;
    model_txn(a, rw, wd, extra, exp_err, exp_cyc);
    run_txn(a, rw, wd, cyc);
    n_checks++;
    if (cyc < exp_cyc - 2 || cyc > exp_cyc + 2) begin
      n_fail++; $display("FAIL %s_cycles: got %0d want %0d+-2", name, cyc, exp_cyc);
    end
    n_checks++;
    if (bus.ack_err !== exp_err) begin
      n_fail++; $display("FAIL %s_ack_err: got %b want %b", name, bus.ack_err, exp_err);
    end
    n_checks++;
    if (bus.rdata !== m_rdata) begin
      n_fail++; $display("FAIL %s_rdata: got %h want %h", name, bus.rdata, m_rdata);
    end
    n_checks++;
    if (s_mem !== m_mem) begin
      n_fail++; $display("FAIL %s_slave_mem: got %h want %h", name, s_mem, m_mem);
    end
    repeat (2 * D) @(negedge clk);
    n_checks++;
    if (s_starts - st0 != 1 || s_stops - sp0 != 1) begin
      n_fail++; $display("FAIL %s_bus_frames: got starts=%0d stops=%0d want 1 1", name,
                         s_starts - st0, s_stops - sp0);
    end
  endtask

  task automatic test_write();
    check_txn("write", SlaveAddr, 1'b0, 8'hA5, 0);
  endtask

  task automatic test_read();
    check_txn("read", SlaveAddr, 1'b1, 8'h00, 0);
    n_checks++;
    if (s_mack !== 1'b1) begin
      n_fail++; $display("FAIL read_master_nack: got %b want 1", s_mack);
    end
  endtask

  task automatic test_nack();
    check_txn("nack", 7'h12, 1'b0, 8'h3C, 0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.ack_err !== 1'b1) begin
      n_fail++; $display("FAIL nack_held: got %b want 1", bus.ack_err);
    end
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic       rw;
    logic [7:0] wd;
    for (int i = 0; i < 6; i++) begin
      a  = ($urandom_range(0, 3) != 0) ? SlaveAddr : 7'($urandom_range(0, 127));
      rw = 1'($urandom_range(0, 1));
      wd = 8'($urandom_range(0, 255));
      check_txn("random", a, rw, wd, 0);
    end
  endtask

  task automatic test_back_to_back();
    int         dc0;
    int         st0;
    int         cyc;
    logic [7:0] wd;
    wd  = 8'($urandom_range(0, 255));
    dc0 = done_cnt;
    st0 = s_starts;
    m_mem = wd;
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = SlaveAddr;
    bus.rw    = 1'b0;
    bus.wdata = wd;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20 * D) @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = 7'h00;
    bus.rw    = 1'b1;
    bus.wdata = ~wd;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < Limit) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20 * D) @(negedge clk);
    n_checks++;
    if (done_cnt - dc0 != 1) begin
      n_fail++; $display("FAIL busy_ignore_done: got %0d pulses want 1", done_cnt - dc0);
    end
    n_checks++;
    if (s_starts - st0 != 1) begin
      n_fail++; $display("FAIL busy_ignore_starts: got %0d want 1", s_starts - st0);
    end
    n_checks++;
    if (s_mem !== m_mem || bus.ack_err !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignore_result: got mem=%h err=%b busy=%b want %h 0 0",
                         s_mem, bus.ack_err, bus.busy, m_mem);
    end
  endtask

  task automatic test_reset_mid();
    int dc0;
    int w;
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = SlaveAddr;
    bus.rw    = 1'b1;
    bus.wdata = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    w = 0;
    while (!(s_phase == SAddr && s_bits == 3) && w < Limit) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= Limit) begin
      n_fail++; $display("FAIL reset_mid_reach_bit4: got timeout want 4th address bit");
    end
    dc0 = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (scl !== 1'b1 || sda !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_release: got scl=%b sda=%b busy=%b want 1 1 0",
                         scl, sda, bus.busy);
    end
    m_rdata = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10 * D) @(negedge clk);
    n_checks++;
    if (done_cnt != dc0) begin
      n_fail++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", done_cnt - dc0);
    end
    check_txn("after_reset", SlaveAddr, 1'b1, 8'h00, 0);
  endtask

`ifdef I2C_MASTER_STRETCH_EN
  task automatic test_stretch();
    logic [7:0] wd;
    wd = 8'($urandom_range(0, 255));
    s_arm = 1'b1;
    check_txn("stretch", SlaveAddr, 1'b0, wd, 3 * D);
    s_arm = 1'b0;
    n_checks++;
    if (s_stretches != 1) begin
      n_fail++; $display("FAIL stretch_applied: got %0d want 1", s_stretches);
    end
    check_txn("stretch_readback", SlaveAddr, 1'b1, 8'h00, 0);
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.addr  = 7'h00;
    bus.rw    = 1'b0;
    bus.wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef I2C_MASTER_STRETCH_EN
    test_stretch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
